// File: rtl/warp_fetcher_pkg.sv
// Shared types for the multi-warp instruction fetcher.
//   warp_state_t                 - scheduler-side per-warp state
//   fetcher_state_t              - fetch status reported to the decoder
//   instruction_t                - one instruction word
//   instruction_memory_address_t - instruction memory address / PC
//   fetch_slot_state_t           - internal per-warp fetch slot state
// `NUM_WARPS supplies the default warp count when not set on the command line.
`ifndef NUM_WARPS
`define NUM_WARPS 4
`endif

package warp_fetcher_pkg;

  typedef enum logic [2:0] {
    WARP_IDLE    = 3'd0,
    WARP_FETCH   = 3'd1,
    WARP_DECODE  = 3'd2,
    WARP_REQUEST = 3'd3,
    WARP_WAIT    = 3'd4,
    WARP_EXECUTE = 3'd5,
    WARP_UPDATE  = 3'd6,
    WARP_DONE    = 3'd7
  } warp_state_t;

  typedef enum logic [1:0] {
    FETCHER_IDLE     = 2'd0,
    FETCHER_FETCHING = 2'd1,
    FETCHER_DONE     = 2'd2
  } fetcher_state_t;

  typedef logic [31:0] instruction_t;
  typedef logic [15:0] instruction_memory_address_t;

  typedef enum logic [1:0] {
    SLOT_IDLE = 2'd0,
    SLOT_PEND = 2'd1,
    SLOT_BUSY = 2'd2,
    SLOT_DONE = 2'd3
  } fetch_slot_state_t;

endpackage

// File: rtl/warp_fetcher_rr_arbiter.sv
// Round-robin arbiter for the shared instruction-memory read channel.
// Ports:
//   clk, reset  - clock, async active-low reset (pointer -> 0)
//   req         - one request bit per warp
//   en          - arbitration allowed this cycle (channel free)
//   gnt         - one-hot grant (only meaningful while en)
//   gnt_idx     - index of the granted warp
//   gnt_valid   - a grant is issued this cycle
// The pointer advances past the winner only when a grant is actually issued.
module warp_fetcher_rr_arbiter #(
  parameter int NUM_WARPS     = 4,
  parameter int WARP_ID_WIDTH = $clog2(NUM_WARPS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_WARPS-1:0]     req,
  input  logic                     en,
  output logic [NUM_WARPS-1:0]     gnt,
  output logic [WARP_ID_WIDTH-1:0] gnt_idx,
  output logic                     gnt_valid
);

  logic [WARP_ID_WIDTH-1:0] ptr_q;

  // Scan from the pointer upward, wrapping, and take the first requester.
  always_comb begin
    int k;
    k         = 0;
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    for (int i = 0; i < NUM_WARPS; i++) begin
      k = int'(ptr_q) + i;
      if (k >= NUM_WARPS) k = k - NUM_WARPS;
      if (en && !gnt_valid && req[k]) begin
        gnt_valid = 1'b1;
        gnt[k]    = 1'b1;
        gnt_idx   = WARP_ID_WIDTH'(k);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q <= '0;
    end else if (gnt_valid) begin
      if (gnt_idx == WARP_ID_WIDTH'(NUM_WARPS - 1)) ptr_q <= '0;
      else                                          ptr_q <= gnt_idx + WARP_ID_WIDTH'(1);
    end
  end

endmodule

// File: rtl/warp_fetcher.sv
// Multi-warp instruction fetch unit: NUM_WARPS per-warp fetch slots share one
// instruction-memory read channel with a single transaction in flight.
// Ports:
//   clk, reset                    - clock, async active-low reset
//   warp_state[w], pc[w]          - per-warp scheduler state and program counter
//   instruction_mem_read_ready    - memory response valid this cycle
//   instruction_mem_read_data     - memory response data
//   instruction_mem_read_valid    - request pending (held until ready)
//   instruction_mem_read_address  - request address (stable while valid)
//   fetcher_state[w]              - IDLE / FETCHING / DONE per warp
//   instruction[w]                - last instruction fetched for warp w
// Optional macro FETCHER_REUSE_EN: per-warp single-entry tag; a fetch of the
// same address as the warp's last completed fetch finishes without memory.
module warp_fetcher
  import warp_fetcher_pkg::*;
#(
  parameter int NUM_WARPS = `NUM_WARPS
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  warp_state_t                 [NUM_WARPS-1:0] warp_state,
  input  instruction_memory_address_t [NUM_WARPS-1:0] pc,
  input  logic                                        instruction_mem_read_ready,
  input  instruction_t                                instruction_mem_read_data,
  output logic                                        instruction_mem_read_valid,
  output instruction_memory_address_t                 instruction_mem_read_address,
  output fetcher_state_t              [NUM_WARPS-1:0] fetcher_state,
  output instruction_t                [NUM_WARPS-1:0] instruction
);

  localparam int WARP_ID_WIDTH = $clog2(NUM_WARPS);

  fetch_slot_state_t           slot_q [NUM_WARPS];
  instruction_memory_address_t pc_q   [NUM_WARPS];

  logic [NUM_WARPS-1:0]     req;
  logic [NUM_WARPS-1:0]     gnt;
  logic [NUM_WARPS-1:0]     hit;
  logic [WARP_ID_WIDTH-1:0] gnt_idx;
  logic                     gnt_valid;
  logic                     mem_done;

  // Only the single BUSY warp can be the target of a completion.
  assign mem_done = instruction_mem_read_valid && instruction_mem_read_ready;

`ifdef FETCHER_REUSE_EN
  instruction_memory_address_t tag_addr_q  [NUM_WARPS];
  logic [NUM_WARPS-1:0]        tag_valid_q;

  always_comb begin
    hit = '0;
    for (int w = 0; w < NUM_WARPS; w++)
      hit[w] = tag_valid_q[w] && (pc[w] == tag_addr_q[w]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_valid_q <= '0;
      for (int w = 0; w < NUM_WARPS; w++) tag_addr_q[w] <= '0;
    end else begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        if (slot_q[w] == SLOT_BUSY && mem_done) begin
          tag_valid_q[w] <= 1'b1;
          tag_addr_q[w]  <= pc_q[w];
        end
      end
    end
  end
`else
  assign hit = '0;
`endif

  // Eligibility comes from registered state, so a warp entering PEND on the
  // same edge as a grant decision waits until the following cycle.
  always_comb begin
    req = '0;
    for (int w = 0; w < NUM_WARPS; w++) req[w] = (slot_q[w] == SLOT_PEND);
  end

  warp_fetcher_rr_arbiter #(
    .NUM_WARPS     (NUM_WARPS),
    .WARP_ID_WIDTH (WARP_ID_WIDTH)
  ) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .en        (!instruction_mem_read_valid),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        slot_q[w]      <= SLOT_IDLE;
        pc_q[w]        <= '0;
        instruction[w] <= '0;
      end
    end else begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        case (slot_q[w])
          SLOT_IDLE: if (warp_state[w] == WARP_FETCH) begin
            pc_q[w]   <= pc[w];
            slot_q[w] <= hit[w] ? SLOT_DONE : SLOT_PEND;
          end
          SLOT_PEND: if (gnt[w]) slot_q[w] <= SLOT_BUSY;
          SLOT_BUSY: if (mem_done) begin
            instruction[w] <= instruction_mem_read_data;
            slot_q[w]      <= SLOT_DONE;
          end
          SLOT_DONE: if (warp_state[w] == WARP_DECODE) slot_q[w] <= SLOT_IDLE;
          default:   slot_q[w] <= SLOT_IDLE;
        endcase
      end
    end
  end

  // Completion drops valid; the arbiter is only enabled while valid is low,
  // which guarantees at least one idle cycle between transactions.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instruction_mem_read_valid   <= 1'b0;
      instruction_mem_read_address <= '0;
    end else if (instruction_mem_read_valid) begin
      if (instruction_mem_read_ready) instruction_mem_read_valid <= 1'b0;
    end else if (gnt_valid) begin
      instruction_mem_read_valid   <= 1'b1;
      instruction_mem_read_address <= pc_q[gnt_idx];
    end
  end

  always_comb begin
    for (int w = 0; w < NUM_WARPS; w++) begin
      case (slot_q[w])
        SLOT_PEND, SLOT_BUSY: fetcher_state[w] = FETCHER_FETCHING;
        SLOT_DONE:            fetcher_state[w] = FETCHER_DONE;
        default:              fetcher_state[w] = FETCHER_IDLE;
      endcase
    end
  end

endmodule
